// File: rtl/nttmul_stage_pkg.sv
// nttmul_stage_pkg: shared widths and default modulus constants for the NTT twiddle multiplier.
package nttmul_stage_pkg;
    localparam int DATA_SIZE_ARB = 16;
    localparam int K_DEF = 14;
    localparam int Q_DEF = 12289;
    localparam int MU_DEF = 21843;
endpackage

// File: rtl/nttmul_stage_barrett_red.sv
// barrett_red: three-stage Barrett reduction of a 2K-bit product with valid and sideband passthrough.
module barrett_red #(
    parameter int K = 14,
    parameter int SB_W = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            in_valid,
    input  logic [2*K-1:0]  p,
    input  logic [K-1:0]    q,
    input  logic [K:0]      mu,
    input  logic [SB_W-1:0] tag,
    output logic            out_valid,
    output logic [K-1:0]    r,
    output logic [SB_W-1:0] r_tag
);
    logic [2*K+1:0] prod;
    logic [K+1:0]   q1, q2, r4;
    logic [K:0]     t3;
    logic [2*K-1:0] p3;
    logic           v3, v4;
    logic [SB_W-1:0] tag3, tag4;

    assign prod = (2*K+2)'(p[2*K-1:K-1]) * (2*K+2)'(mu);
    assign q1 = (K+2)'(q);
    assign q2 = q1 << 1;

    // r only needs K+2 bits since the Barrett estimate leaves r < 3q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3 <= 1'b0;
            t3 <= '0;
            p3 <= '0;
            tag3 <= '0;
            v4 <= 1'b0;
            r4 <= '0;
            tag4 <= '0;
            out_valid <= 1'b0;
            r <= '0;
            r_tag <= '0;
        end else if (en) begin
            v3 <= in_valid;
            t3 <= (K+1)'(prod >> (K+1));
            p3 <= p;
            tag3 <= tag;
            v4 <= v3;
            r4 <= (K+2)'(p3 - (2*K)'(t3) * (2*K)'(q));
            tag4 <= tag3;
            out_valid <= v4;
            r <= (r4 >= q2) ? K'(r4 - q2) : (r4 >= q1) ? K'(r4 - q1) : K'(r4);
            r_tag <= tag4;
        end
    end
endmodule

// File: rtl/nttmul_stage.sv
// nttmul_stage: five-stage v*w mod q multiplier feeding the butterfly combiner, with u/sel carried aligned.
module nttmul_stage
    import nttmul_stage_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE_ARB,
    parameter int K = K_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] q,
    input  logic [K:0]        mu,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] u_i,
    input  logic [DATA_W-1:0] v_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic              sel_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] u_o,
    output logic [DATA_W-1:0] vw_o,
    output logic              sel_o
);
    logic              en, vld1, vld2, sel1, sel2;
    logic [DATA_W-1:0] u1, v1, w1, u2;
    logic [2*K-1:0]    p2;
    logic [K-1:0]      r;
    logic [DATA_W:0]   tag_out;

    // one global enable: a stalled output freezes every stage, bubbles included
    assign en = ~out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1 <= 1'b0;
            u1 <= '0;
            v1 <= '0;
            w1 <= '0;
            sel1 <= 1'b0;
            vld2 <= 1'b0;
            u2 <= '0;
            sel2 <= 1'b0;
            p2 <= '0;
        end else if (en) begin
            vld1 <= in_valid;
            u1 <= u_i;
            v1 <= v_i;
            w1 <= w_i;
            sel1 <= sel_i;
            vld2 <= vld1;
            u2 <= u1;
            sel2 <= sel1;
            p2 <= (2*K)'((2*DATA_W)'(v1) * (2*DATA_W)'(w1));
        end
    end

    barrett_red #(.K(K), .SB_W(DATA_W + 1)) u_red (
        .clk(clk),
        .reset(reset),
        .en(en),
        .in_valid(vld2),
        .p(p2),
        .q(K'(q)),
        .mu(mu),
        .tag({u2, sel2}),
        .out_valid(out_valid),
        .r(r),
        .r_tag(tag_out)
    );

    assign u_o = tag_out[DATA_W:1];
    assign sel_o = tag_out[0];
    assign vw_o = DATA_W'(r);
endmodule
